// File: rtl/wb_stage_ex_pkg.sv
// Shared definitions for the writeback stage.
// Holds the exception code constants used across the pipeline and the helper
// functions that size the packed MEM->WB and WB->ID buses from the stage
// parameters. Bus field offsets are derived from these in the stage itself.
package wb_stage_ex_pkg;

   localparam int ECODE_W = 6;
   localparam int ESUB_W  = 9;

   localparam logic [ECODE_W-1:0] ECODE_INT = 6'h00;
   localparam logic [ECODE_W-1:0] ECODE_ADE = 6'h08;
   localparam logic [ECODE_W-1:0] ECODE_ALE = 6'h09;
   localparam logic [ECODE_W-1:0] ECODE_SYS = 6'h0B;
   localparam logic [ECODE_W-1:0] ECODE_BRK = 6'h0C;
   localparam logic [ECODE_W-1:0] ECODE_INE = 6'h0D;

   // MEM->WB bus, LSB->MSB:
   // pc, gr_we, dest, result, csr_we, csr_num, csr_wmask, csr_wvalue,
   // ex, ecode, esubcode, ertn
   function automatic int ms2ws_width(input int data_w, input int reg_aw,
                                      input int pc_w, input int csr_aw);
      return pc_w + 1 + reg_aw + data_w + 1 + csr_aw + data_w + data_w
             + 1 + ECODE_W + ESUB_W + 1;
   endfunction

   // WB->ID forwarding bus: {csr_hzd, ws_valid, rf_we, waddr, wdata}
   function automatic int ws2ds_width(input int data_w, input int reg_aw);
      return reg_aw + data_w + 3;
   endfunction

endpackage

// File: rtl/wb_retire_counter.sv
// Retired-instruction counter.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-high reset, clears the count
//   inc    - add one to the count on this edge
//   count  - current count, wraps modulo 2^CNT_W without saturating
module wb_retire_counter #(
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   // Free-running wrap: overflow simply rolls back to zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (inc) begin
         count <= count + ONE;
      end
   end

endmodule

// File: rtl/wb_stage_ex.sv
// Writeback stage (5th pipe stage).
// Latches the MEM->WB bus, commits GPR writes, raises the exception/ERTN
// flush along with the CSR-commit information for the CSR unit, forwards the
// committing write to ID, counts retired instructions and drives the debug
// trace port.
// Ports:
//   clk, reset                 - clock and asynchronous active-high reset
//   ms_to_ws_valid/_bus        - instruction offered by MEM
//   ws_allow_in                - WB can accept an instruction this cycle
//   ws_to_ds_bus               - {csr_hzd, ws_valid, rf_we, waddr, wdata} to ID
//   ws_flush                   - exception or ERTN committing this cycle
//   wb_ex/wb_ertn/wb_ecode/wb_esubcode/wb_pc - exception commit info
//   csr_we/csr_num/csr_wmask/csr_wvalue      - CSR write port
//   retire_cnt                 - retired-instruction count
//   debug_wb_*                 - trace port
module wb_stage_ex
   import wb_stage_ex_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int REG_AW    = 5,
   parameter int PC_W      = 32,
   parameter int CSR_AW    = 14,
   parameter int RET_CNT_W = 64,
   parameter int DBG_WE_W  = 4
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic                                    ms_to_ws_valid,
   input  logic [ms2ws_width(DATA_W, REG_AW, PC_W, CSR_AW)-1:0] ms_to_ws_bus,
   output logic                                    ws_allow_in,
   output logic [ws2ds_width(DATA_W, REG_AW)-1:0]  ws_to_ds_bus,
   output logic                                    ws_flush,
   output logic                                    wb_ex,
   output logic                                    wb_ertn,
   output logic [ECODE_W-1:0]                      wb_ecode,
   output logic [ESUB_W-1:0]                       wb_esubcode,
   output logic [PC_W-1:0]                         wb_pc,
   output logic                                    csr_we,
   output logic [CSR_AW-1:0]                       csr_num,
   output logic [DATA_W-1:0]                       csr_wmask,
   output logic [DATA_W-1:0]                       csr_wvalue,
   output logic [RET_CNT_W-1:0]                    retire_cnt,
   output logic [PC_W-1:0]                         debug_wb_pc,
   output logic [DBG_WE_W-1:0]                     debug_wb_rf_we,
   output logic [REG_AW-1:0]                       debug_wb_rf_wnum,
   output logic [DATA_W-1:0]                       debug_wb_rf_wdata
);

   localparam int MS2WS_W = ms2ws_width(DATA_W, REG_AW, PC_W, CSR_AW);

   localparam int PC_LSB         = 0;
   localparam int GR_WE_BIT      = PC_LSB + PC_W;
   localparam int DEST_LSB       = GR_WE_BIT + 1;
   localparam int RESULT_LSB     = DEST_LSB + REG_AW;
   localparam int CSR_WE_BIT     = RESULT_LSB + DATA_W;
   localparam int CSR_NUM_LSB    = CSR_WE_BIT + 1;
   localparam int CSR_WMASK_LSB  = CSR_NUM_LSB + CSR_AW;
   localparam int CSR_WVALUE_LSB = CSR_WMASK_LSB + DATA_W;
   localparam int EX_BIT         = CSR_WVALUE_LSB + DATA_W;
   localparam int ECODE_LSB      = EX_BIT + 1;
   localparam int ESUB_LSB       = ECODE_LSB + ECODE_W;
   localparam int ERTN_BIT       = ESUB_LSB + ESUB_W;

   logic               ws_valid;
   logic [MS2WS_W-1:0] bus_r;
   logic               ws_ready_go;

   logic               f_gr_we;
   logic [REG_AW-1:0]  f_dest;
   logic [DATA_W-1:0]  f_result;
   logic               f_csr_we;
   logic               f_ex;
   logic               f_ertn;
   logic               rf_we;
   logic               csr_hzd;

   // WB never stalls, so it always accepts; the handshake form is kept so a
   // future multi-cycle commit only has to change ws_ready_go.
   assign ws_ready_go = 1'b1;
   assign ws_allow_in = ~ws_valid | ws_ready_go;

   // The bus register only loads on an accepted handshake and otherwise keeps
   // its last contents; ws_valid alone decides whether they mean anything.
   // An instruction arriving while a flush commits is dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ws_valid <= 1'b0;
         bus_r    <= '0;
      end else begin
         if (ws_allow_in) begin
            ws_valid <= ms_to_ws_valid & ~ws_flush;
         end
         if (ms_to_ws_valid & ws_allow_in) begin
            bus_r <= ms_to_ws_bus;
         end
      end
   end

   assign f_gr_we  = bus_r[GR_WE_BIT];
   assign f_dest   = bus_r[DEST_LSB +: REG_AW];
   assign f_result = bus_r[RESULT_LSB +: DATA_W];
   assign f_csr_we = bus_r[CSR_WE_BIT];
   assign f_ex     = bus_r[EX_BIT];
   assign f_ertn   = bus_r[ERTN_BIT];

   // Exception outranks ERTN, and a faulting instruction commits no GPR or
   // CSR write.
   assign wb_ex    = ws_valid & f_ex;
   assign wb_ertn  = ws_valid & f_ertn & ~f_ex;
   assign ws_flush = wb_ex | wb_ertn;
   assign rf_we    = ws_valid & f_gr_we & ~f_ex;
   assign csr_we   = ws_valid & f_csr_we & ~f_ex;
   assign csr_hzd  = ws_valid & (f_csr_we | f_ex | f_ertn);

   assign wb_ecode    = bus_r[ECODE_LSB +: ECODE_W];
   assign wb_esubcode = bus_r[ESUB_LSB +: ESUB_W];
   assign wb_pc       = bus_r[PC_LSB +: PC_W];
   assign csr_num     = bus_r[CSR_NUM_LSB +: CSR_AW];
   assign csr_wmask   = bus_r[CSR_WMASK_LSB +: DATA_W];
   assign csr_wvalue  = bus_r[CSR_WVALUE_LSB +: DATA_W];

   assign ws_to_ds_bus = {csr_hzd, ws_valid, rf_we, f_dest, f_result};

   assign debug_wb_pc       = bus_r[PC_LSB +: PC_W];
   assign debug_wb_rf_we    = {DBG_WE_W{rf_we}};
   assign debug_wb_rf_wnum  = f_dest;
   assign debug_wb_rf_wdata = f_result;

   // ERTN retires normally; only an exception-raising instruction does not.
   wb_retire_counter #(
      .CNT_W (RET_CNT_W)
   ) u_retire_counter (
      .clk   (clk),
      .reset (reset),
      .inc   (ws_valid & ~f_ex),
      .count (retire_cnt)
   );

endmodule

// File: tb/tb_wb_stage_ex.sv
// Testbench for wb_stage_ex: directed instruction sequences checked every
// cycle against an instruction-level model, plus hand-computed expectations.
module tb_wb_stage_ex;

   localparam int RET_W = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          ms_to_ws_valid;
   logic [165:0]  ms_to_ws_bus;
   logic          ws_allow_in;
   logic [39:0]   ws_to_ds_bus;
   logic          ws_flush;
   logic          wb_ex;
   logic          wb_ertn;
   logic [5:0]    wb_ecode;
   logic [8:0]    wb_esubcode;
   logic [31:0]   wb_pc;
   logic          csr_we;
   logic [13:0]   csr_num;
   logic [31:0]   csr_wmask;
   logic [31:0]   csr_wvalue;
   logic [RET_W-1:0] retire_cnt;
   logic [31:0]   debug_wb_pc;
   logic [3:0]    debug_wb_rf_we;
   logic [4:0]    debug_wb_rf_wnum;
   logic [31:0]   debug_wb_rf_wdata;

   wb_stage_ex #(
      .DATA_W    (32),
      .REG_AW    (5),
      .PC_W      (32),
      .CSR_AW    (14),
      .RET_CNT_W (RET_W),
      .DBG_WE_W  (4)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .ms_to_ws_valid    (ms_to_ws_valid),
      .ms_to_ws_bus      (ms_to_ws_bus),
      .ws_allow_in       (ws_allow_in),
      .ws_to_ds_bus      (ws_to_ds_bus),
      .ws_flush          (ws_flush),
      .wb_ex             (wb_ex),
      .wb_ertn           (wb_ertn),
      .wb_ecode          (wb_ecode),
      .wb_esubcode       (wb_esubcode),
      .wb_pc             (wb_pc),
      .csr_we            (csr_we),
      .csr_num           (csr_num),
      .csr_wmask         (csr_wmask),
      .csr_wvalue        (csr_wvalue),
      .retire_cnt        (retire_cnt),
      .debug_wb_pc       (debug_wb_pc),
      .debug_wb_rf_we    (debug_wb_rf_we),
      .debug_wb_rf_wnum  (debug_wb_rf_wnum),
      .debug_wb_rf_wdata (debug_wb_rf_wdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] result;
      logic        csr_we;
      logic [13:0] csr_num;
      logic [31:0] wmask;
      logic [31:0] wvalue;
      logic        ex;
      logic [5:0]  ecode;
      logic [8:0]  esub;
      logic        ertn;
   } instr_t;

   int checks = 0;
   int errors = 0;

   instr_t drv;
   instr_t m_cur;
   logic   m_valid = 1'b0;
   int     m_cnt = 0;
   logic   m_flush_now;
   logic [36:0] trace_q[$];

   function automatic instr_t blank();
      instr_t i;
      i.pc = '0; i.gr_we = 1'b0; i.dest = '0; i.result = '0;
      i.csr_we = 1'b0; i.csr_num = '0; i.wmask = '0; i.wvalue = '0;
      i.ex = 1'b0; i.ecode = '0; i.esub = '0; i.ertn = 1'b0;
      return i;
   endfunction

   function automatic instr_t mk_alu(input logic [31:0] pc, input logic [4:0] dest,
                                     input logic [31:0] result);
      instr_t i;
      i = blank();
      i.pc = pc; i.gr_we = 1'b1; i.dest = dest; i.result = result;
      return i;
   endfunction

   function automatic logic [165:0] pack_instr(input instr_t i);
      return {i.ertn, i.esub, i.ecode, i.ex, i.wvalue, i.wmask, i.csr_num,
              i.csr_we, i.result, i.dest, i.gr_we, i.pc};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input instr_t i, input logic v);
      @(posedge clk);
      #1;
      drv            = i;
      ms_to_ws_bus   = pack_instr(i);
      ms_to_ws_valid = v;
   endtask

   // Instruction-level model: which instruction sits in WB, whether it is
   // live, and how many have retired.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_cur   = blank();
         m_valid = 1'b0;
         m_cnt   = 0;
      end else begin
         m_flush_now = m_valid & (m_cur.ex | m_cur.ertn);
         if (m_valid && !m_cur.ex) m_cnt = (m_cnt + 1) % (1 << RET_W);
         if (ms_to_ws_valid) m_cur = drv;
         m_valid = ms_to_ws_valid & ~m_flush_now;
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      logic e_ex, e_ertn, e_rfwe, e_csrwe, e_hzd;
      e_ex    = m_valid & m_cur.ex;
      e_ertn  = m_valid & m_cur.ertn & ~m_cur.ex;
      e_rfwe  = m_valid & m_cur.gr_we & ~m_cur.ex;
      e_csrwe = m_valid & m_cur.csr_we & ~m_cur.ex;
      e_hzd   = m_valid & (m_cur.csr_we | m_cur.ex | m_cur.ertn);
      checkOutput("allow_in", 64'(ws_allow_in), 64'd1);
      checkOutput("flush", 64'(ws_flush), 64'(e_ex | e_ertn));
      checkOutput("wb_ex", 64'(wb_ex), 64'(e_ex));
      checkOutput("wb_ertn", 64'(wb_ertn), 64'(e_ertn));
      checkOutput("ecode", 64'(wb_ecode), 64'(m_cur.ecode));
      checkOutput("esubcode", 64'(wb_esubcode), 64'(m_cur.esub));
      checkOutput("wb_pc", 64'(wb_pc), 64'(m_cur.pc));
      checkOutput("csr_we", 64'(csr_we), 64'(e_csrwe));
      checkOutput("csr_num", 64'(csr_num), 64'(m_cur.csr_num));
      checkOutput("csr_wmask", 64'(csr_wmask), 64'(m_cur.wmask));
      checkOutput("csr_wvalue", 64'(csr_wvalue), 64'(m_cur.wvalue));
      checkOutput("retire_cnt", 64'(retire_cnt), 64'(m_cnt));
      checkOutput("ws_to_ds", 64'(ws_to_ds_bus),
                  64'({e_hzd, m_valid, e_rfwe, m_cur.dest, m_cur.result}));
      checkOutput("dbg_pc", 64'(debug_wb_pc), 64'(m_cur.pc));
      checkOutput("dbg_we", 64'(debug_wb_rf_we), 64'({4{e_rfwe}}));
      checkOutput("dbg_wnum", 64'(debug_wb_rf_wnum), 64'(m_cur.dest));
      checkOutput("dbg_wdata", 64'(debug_wb_rf_wdata), 64'(m_cur.result));
      if (debug_wb_rf_we != 4'd0) trace_q.push_back({debug_wb_rf_wnum, debug_wb_rf_wdata});
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      instr_t t;
      logic [36:0] exp_tr [3];
      exp_tr[0] = {5'd1, 32'h11};
      exp_tr[1] = {5'd2, 32'h22};
      exp_tr[2] = {5'd3, 32'h33};

      drv            = blank();
      ms_to_ws_valid = 1'b0;
      ms_to_ws_bus   = '0;
      reset          = 1'b1;
      #3;
      checkOutput("reset_allow_in", 64'(ws_allow_in), 64'd1);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checkOutput("reset_cnt", 64'(retire_cnt), 64'd0);
      checkOutput("reset_flush", 64'(ws_flush), 64'd0);

      $display("[TB] back-to-back ALU ops");
      trace_q.delete();
      applyStimulus(mk_alu(32'h1c000000, 5'd1, 32'h11), 1'b1);
      applyStimulus(mk_alu(32'h1c000004, 5'd2, 32'h22), 1'b1);
      applyStimulus(mk_alu(32'h1c000008, 5'd3, 32'h33), 1'b1);
      applyStimulus(blank(), 1'b0);
      @(posedge clk); @(negedge clk);
      checkOutput("alu_cnt", 64'(retire_cnt), 64'd3);
      checkOutput("alu_trace_n", 64'(trace_q.size()), 64'd3);
      for (int k = 0; k < 3; k++)
         checkOutput($sformatf("alu_trace%0d", k),
                     (k < trace_q.size()) ? 64'(trace_q[k]) : 64'hDEAD, 64'(exp_tr[k]));

      $display("[TB] exception commit");
      t = mk_alu(32'h1c000100, 5'd5, 32'h55);
      t.ex = 1'b1; t.ecode = 6'h0B;
      applyStimulus(t, 1'b1);
      applyStimulus(blank(), 1'b0);
      @(negedge clk);
      checkOutput("ex_wb_ex", 64'(wb_ex), 64'd1);
      checkOutput("ex_flush", 64'(ws_flush), 64'd1);
      checkOutput("ex_rf_we", 64'(debug_wb_rf_we), 64'd0);
      checkOutput("ex_ecode", 64'(wb_ecode), 64'h0B);
      @(posedge clk); @(negedge clk);
      checkOutput("ex_one_cycle", 64'(wb_ex), 64'd0);
      checkOutput("ex_cnt", 64'(retire_cnt), 64'd3);

      $display("[TB] op behind exception is dropped");
      trace_q.delete();
      applyStimulus(t, 1'b1);
      applyStimulus(mk_alu(32'h1c000104, 5'd7, 32'h77), 1'b1);
      applyStimulus(blank(), 1'b0);
      @(negedge clk);
      checkOutput("drop_valid", 64'(ws_to_ds_bus[38]), 64'd0);
      @(posedge clk); @(negedge clk);
      checkOutput("drop_trace_n", 64'(trace_q.size()), 64'd0);
      checkOutput("drop_cnt", 64'(retire_cnt), 64'd3);

      $display("[TB] ex with ertn, then ertn alone");
      t = blank(); t.pc = 32'h1c000200; t.ex = 1'b1; t.ertn = 1'b1; t.ecode = 6'h0C;
      applyStimulus(t, 1'b1);
      applyStimulus(blank(), 1'b0);
      @(negedge clk);
      checkOutput("exertn_ex", 64'(wb_ex), 64'd1);
      checkOutput("exertn_ertn", 64'(wb_ertn), 64'd0);
      t = blank(); t.pc = 32'h1c000204; t.ertn = 1'b1;
      applyStimulus(t, 1'b1);
      applyStimulus(blank(), 1'b0);
      @(negedge clk);
      checkOutput("ertn_ertn", 64'(wb_ertn), 64'd1);
      checkOutput("ertn_hzd", 64'(ws_to_ds_bus[39]), 64'd1);
      checkOutput("ertn_flush", 64'(ws_flush), 64'd1);
      @(posedge clk); @(negedge clk);
      checkOutput("ertn_cnt", 64'(retire_cnt), 64'd4);

      $display("[TB] csrwr");
      t = mk_alu(32'h1c000300, 5'd4, 32'h0);
      t.csr_we = 1'b1; t.csr_num = 14'h6; t.wmask = 32'hFFFFFFFF; t.wvalue = 32'h1234;
      applyStimulus(t, 1'b1);
      applyStimulus(blank(), 1'b0);
      @(negedge clk);
      checkOutput("csr_we_lit", 64'(csr_we), 64'd1);
      checkOutput("csr_num_lit", 64'(csr_num), 64'h6);
      checkOutput("csr_wmask_lit", 64'(csr_wmask), 64'hFFFFFFFF);
      checkOutput("csr_wvalue_lit", 64'(csr_wvalue), 64'h1234);
      @(posedge clk); @(negedge clk);
      checkOutput("csr_cnt", 64'(retire_cnt), 64'd5);

      $display("[TB] reset mid-stream");
      applyStimulus(mk_alu(32'h1c000400, 5'd8, 32'h88), 1'b1);
      applyStimulus(mk_alu(32'h1c000404, 5'd9, 32'h99), 1'b1);
      #2 reset = 1'b1;
      #1;
      checkOutput("rst_valid", 64'(ws_to_ds_bus[38]), 64'd0);
      checkOutput("rst_cnt", 64'(retire_cnt), 64'd0);
      checkOutput("rst_dbg_we", 64'(debug_wb_rf_we), 64'd0);
      checkOutput("rst_pc", 64'(wb_pc), 64'd0);
      @(posedge clk);
      #1;
      reset          = 1'b0;
      ms_to_ws_valid = 1'b0;

      $display("[TB] counter wrap");
      for (int i = 0; i < 16; i++)
         applyStimulus(mk_alu(32'h1c001000 + 32'(i * 4), 5'(i), 32'(i * 32'h101)), 1'b1);
      applyStimulus(blank(), 1'b0);
      @(negedge clk);
      checkOutput("wrap_cnt15", 64'(retire_cnt), 64'd15);
      @(posedge clk); @(negedge clk);
      checkOutput("wrap_cnt0", 64'(retire_cnt), 64'd0);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
